// File: rtl/sdram_aref_pkg.sv
// sdram_aref_pkg
//   Shared definitions for the SDRAM auto-refresh controller: command bus
//   encodings {CS_N,RAS_N,CAS_N,WE_N}, address width, FSM state type and
//   small helper functions used by sdram_aref and sdram_ref_timer.
//   No ports.
package sdram_aref_pkg;

  localparam int ASIZE   = 13;
  localparam int A10_BIT = 10;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE      = 3'd1,
    ST_WAIT_RP  = 3'd2,
    ST_AREF1    = 3'd3,
    ST_WAIT_RC1 = 3'd4,
    ST_AREF2    = 3'd5,
    ST_WAIT_RC2 = 3'd6,
    ST_DONE     = 3'd7
  } aref_state_e;

  // Command driven while the FSM sits in a given state.
  function automatic logic [3:0] state_cmd(input aref_state_e s);
    logic [3:0] c;
    c = CMD_NOP;
    case (s)
      ST_PRE:   c = CMD_PRECHARGE;
      ST_AREF1: c = CMD_AREF;
      ST_AREF2: c = CMD_AREF;
      default:  c = CMD_NOP;
    endcase
    return c;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// sdram_ref_timer
//   Periodic refresh timer. Counts 0..REF_PERIOD-1 while en_i is high and
//   wraps; each wrap sets a sticky request flag. The flag is a single bit:
//   wraps while it is already set are not counted. Dropping en_i clears both
//   the count and the flag on the next clock.
// Ports
//   Clk     in  system clock
//   Rst_n   in  asynchronous active-low reset
//   en_i    in  count enable (device initialised)
//   clr_i   in  request consumed; wins over a wrap in the same cycle
//   req_o   out registered sticky refresh request
module sdram_ref_timer
  import sdram_aref_pkg::*;
#(
  parameter int REF_PERIOD = 780
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic req_o
);

  localparam int CW = max_int($clog2(REF_PERIOD), 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          wrap;

  assign wrap = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A grant coinciding with a wrap absorbs that wrap.
  always_comb begin
    req_d = req_q;
    if (!en_i) begin
      req_d = 1'b0;
    end else if (clr_i) begin
      req_d = 1'b0;
    end else if (wrap) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      req_q <= req_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/sdram_aref.sv
// sdram_aref
//   SDRAM auto-refresh controller. A periodic timer raises Aref_req; once
//   the arbiter grants it (Aref_en in IDLE), the block issues PRECHARGE-ALL
//   then two AUTO REFRESH commands spaced by tRP/tRC, and pulses Aref_done.
//   Init_done low aborts synchronously to IDLE. All outputs are registered.
// Ports
//   Clk        in  system clock (SDRAM device clock is ~Clk)
//   Rst_n      in  asynchronous active-low reset
//   Init_done  in  device initialised (level)
//   Aref_en    in  arbiter grant, sampled only in IDLE with a pending request
//   Aref_req   out refresh pending
//   Aref_done  out one-cycle end-of-sequence pulse
//   Command    out {CS_N,RAS_N,CAS_N,WE_N}
//   Saddr      out address bus, A10 set during PRECHARGE only
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | waiting for request + grant
// ST_PRE       | PRECHARGE-ALL on the bus (1 cycle)
// ST_WAIT_RP   | tRP spacing, TRP_CLK-1 cycles (skipped if TRP_CLK=1)
// ST_AREF1     | first AUTO REFRESH (1 cycle)
// ST_WAIT_RC1  | tRC spacing, TRC_CLK-1 cycles (skipped if TRC_CLK=1)
// ST_AREF2     | second AUTO REFRESH (1 cycle)
// ST_WAIT_RC2  | tRC spacing, TRC_CLK-1 cycles (skipped if TRC_CLK=1)
// ST_DONE      | Aref_done pulse (1 cycle)
module sdram_aref
  import sdram_aref_pkg::*;
#(
  parameter int REF_PERIOD = 780,
  parameter int TRP_CLK    = 2,
  parameter int TRC_CLK    = 7
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Init_done,
  input  logic             Aref_en,
  output logic             Aref_req,
  output logic             Aref_done,
  output logic [3:0]       Command,
  output logic [ASIZE-1:0] Saddr
);

  localparam int DLY_W = max_int($clog2(max_int(TRP_CLK, TRC_CLK) + 1), 1);
  // Last delay-counter value inside a wait state; the counter starts at 0
  // on entry and the wait lasts N-1 cycles.
  localparam logic [DLY_W-1:0] RP_LAST = DLY_W'((TRP_CLK > 1) ? TRP_CLK - 2 : 0);
  localparam logic [DLY_W-1:0] RC_LAST = DLY_W'((TRC_CLK > 1) ? TRC_CLK - 2 : 0);
  localparam logic [ASIZE-1:0] A10_MASK = ASIZE'(1) << A10_BIT;

  aref_state_e      state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [ASIZE-1:0] saddr_q, saddr_d;
  logic             done_q, done_d;
  logic             grant;
  logic             timer_req;

  sdram_ref_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_timer (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .en_i (Init_done),
    .clr_i(grant),
    .req_o(timer_req)
  );

  // dly_d defaults to 0, so any state change clears the delay counter;
  // it only advances while a wait state holds.
  always_comb begin
    state_d = state_q;
    dly_d   = '0;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (timer_req && Aref_en) begin
          grant   = 1'b1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        state_d = (TRP_CLK > 1) ? ST_WAIT_RP : ST_AREF1;
      end
      ST_WAIT_RP: begin
        if (dly_q == RP_LAST) begin
          state_d = ST_AREF1;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_AREF1: begin
        state_d = (TRC_CLK > 1) ? ST_WAIT_RC1 : ST_AREF2;
      end
      ST_WAIT_RC1: begin
        if (dly_q == RC_LAST) begin
          state_d = ST_AREF2;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_AREF2: begin
        state_d = (TRC_CLK > 1) ? ST_WAIT_RC2 : ST_DONE;
      end
      ST_WAIT_RC2: begin
        if (dly_q == RC_LAST) begin
          state_d = ST_DONE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Loss of Init_done overrides everything, including a pending grant.
    if (!Init_done) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      grant   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they line up with the
  // registered state.
  always_comb begin
    cmd_d   = state_cmd(state_d);
    saddr_d = (state_d == ST_PRE) ? A10_MASK : '0;
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      cmd_q   <= CMD_NOP;
      saddr_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cmd_q   <= cmd_d;
      saddr_q <= saddr_d;
      done_q  <= done_d;
    end
  end

  assign Aref_req  = timer_req;
  assign Aref_done = done_q;
  assign Command   = cmd_q;
  assign Saddr     = saddr_q;

endmodule

// File: tb/tb_sdram_aref.sv
module tb_sdram_aref;
  import sdram_aref_pkg::*;

  localparam int REF_P = 50;
  localparam int TRP   = 2;
  localparam int TRC   = 7;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PREC = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [ASIZE-1:0] A10_ADDR = ASIZE'(1024);

  logic             Clk = 1'b0;
  logic             Rst_n;
  logic             Init_done;
  logic             Aref_en;
  logic             Aref_req;
  logic             Aref_done;
  logic [3:0]       Command;
  logic [ASIZE-1:0] Saddr;

  typedef struct {
    int               cyc;
    logic [3:0]       cmd;
    logic [ASIZE-1:0] addr;
    logic             done;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  sdram_aref #(
    .REF_PERIOD(REF_P),
    .TRP_CLK   (TRP),
    .TRC_CLK   (TRC)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Init_done(Init_done),
    .Aref_en  (Aref_en),
    .Aref_req (Aref_req),
    .Aref_done(Aref_done),
    .Command  (Command),
    .Saddr    (Saddr)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_req(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (Aref_req === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("req_timeout", {31'b0, Aref_req}, 32'd1);
  endtask

  // Expected bus events of a full sequence whose PRECHARGE lands at c0.
  task automatic push_seq(input int c0);
    exp_q.push_back('{c0,               PREC, A10_ADDR, 1'b0});
    exp_q.push_back('{c0 + TRP,         AREF, '0,       1'b0});
    exp_q.push_back('{c0 + TRP + TRC,   AREF, '0,       1'b0});
    exp_q.push_back('{c0 + TRP + 2*TRC, NOP,  '0,       1'b1});
  endtask

  task automatic push_first2(input int c0);
    exp_q.push_back('{c0,       PREC, A10_ADDR, 1'b0});
    exp_q.push_back('{c0 + TRP, AREF, '0,       1'b0});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd"},  {28'b0, Command}, {28'b0, NOP});
    check({tag, "_addr"}, {19'b0, Saddr},   32'd0);
    check({tag, "_req"},  {31'b0, Aref_req},  32'd0);
    check({tag, "_done"}, {31'b0, Aref_done}, 32'd0);
  endtask

  // Every non-NOP command or done pulse must match the head of the scoreboard.
  always @(posedge Clk) begin
    #1;
    if (Command !== NOP || Aref_done !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("spurious_evt", {27'b0, Aref_done, Command}, {27'b0, 1'b0, NOP});
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_cycle", cyc, mon_e.cyc);
        check("evt_cmd",  {28'b0, Command},   {28'b0, mon_e.cmd});
        check("evt_addr", {19'b0, Saddr},     {19'b0, mon_e.addr});
        check("evt_done", {31'b0, Aref_done}, {31'b0, mon_e.done});
      end
    end
  end

  initial begin
    int r, w, w2, big_w, c0, n_bad;

    // 1: reset held, then released with Init_done low
    Rst_n = 1'b0; Init_done = 1'b0; Aref_en = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    Rst_n = 1'b1;
    n_bad = 0;
    repeat (200) begin
      tick();
      if (Aref_req !== 1'b0 || Command !== NOP) n_bad++;
    end
    check("no_req_uninit", n_bad, 0);

    // 2: Init_done rises, grant tied high
    Aref_en = 1'b1; Init_done = 1'b1; r = cyc;
    wait_req(100, w);
    check("first_req_delay", w - r, REF_P);
    push_seq(w + 1);
    tick();
    check("req_clear_on_grant", {31'b0, Aref_req}, 32'd0);
    wait_until(w + 1 + TRP + 2*TRC + 1);
    check("done_one_cycle", {31'b0, Aref_done}, 32'd0);
    check("seq1_complete", exp_q.size(), 0);
    wait_req(100, w2);
    check("req_period", w2 - w, REF_P);
    push_seq(w2 + 1);
    tick();
    Aref_en = 1'b0;
    wait_until(w2 + 1 + TRP + 2*TRC + 1);
    check("seq2_complete", exp_q.size(), 0);

    // 3: grant withheld 200 cycles; release on a wrap cycle
    wait_req(100, big_w);
    check("req_period2", big_w - w2, REF_P);
    n_bad = 0;
    while (cyc < big_w + 199) begin
      tick();
      if (Aref_req !== 1'b1) n_bad++;
    end
    check("req_held", n_bad, 0);
    Aref_en = 1'b1;
    push_seq(big_w + 200);
    tick();
    check("wrap_absorbed", {31'b0, Aref_req}, 32'd0);
    wait_until(big_w + 217);
    Aref_en = 1'b0;
    wait_until(big_w + 249);
    check("no_req_before_wrap", {31'b0, Aref_req}, 32'd0);
    tick();
    check("req_at_wrap", {31'b0, Aref_req}, 32'd1);
    check("seq3_complete", exp_q.size(), 0);

    // 4: grant pulses mid-sequence and with no request pending
    Aref_en = 1'b1;
    push_seq(big_w + 251);
    tick(); tick();
    Aref_en = 1'b0; tick(); tick();
    Aref_en = 1'b1; tick();
    Aref_en = 1'b0; tick();
    Aref_en = 1'b1; tick();
    Aref_en = 1'b0;
    wait_until(big_w + 268);
    Aref_en = 1'b1;
    repeat (3) tick();
    Aref_en = 1'b0;
    check("no_req_after_pulse", {31'b0, Aref_req}, 32'd0);
    wait_until(big_w + 299);
    check("no_req_pre_wrap2", {31'b0, Aref_req}, 32'd0);
    check("seq4_complete", exp_q.size(), 0);
    tick();
    check("req_at_wrap2", {31'b0, Aref_req}, 32'd1);

    // 5: Init_done dropped during WAIT_RC1
    Aref_en = 1'b1;
    c0 = big_w + 301;
    push_first2(c0);
    wait_until(c0 + 4);
    Init_done = 1'b0;
    tick();
    Aref_en = 1'b0;
    check_idle_outputs("abort");
    repeat (12) tick();
    check("abort_no_more_evts", exp_q.size(), 0);
    Init_done = 1'b1; r = cyc;
    wait_req(100, w);
    check("req_after_restore", w - r, REF_P);

    // 6: async reset during AREF1
    Aref_en = 1'b1;
    c0 = w + 1;
    push_first2(c0);
    wait_until(c0 + TRP);
    Aref_en = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    tick(); tick();
    Rst_n = 1'b1; r = cyc;
    wait_req(100, w);
    check("req_after_reset", w - r, REF_P);
    check("rst_no_more_evts", exp_q.size(), 0);
    Aref_en = 1'b1;
    push_seq(w + 1);
    wait_until(w + 1 + TRP + 2*TRC + 2);
    Aref_en = 1'b0;
    check("final_done_low", {31'b0, Aref_done}, 32'd0);
    check("final_complete", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_aref.md
# sdram_aref

Auto-refresh controller for the SDRAM interface. It sits directly downstream of `sdram_init` and becomes active once `Init_done` rises. A periodic refresh timer raises a request to the command arbiter. When the arbiter grants it, the block drives a PRECHARGE-ALL followed by two AUTO REFRESH commands, with tRP/tRC spacing, onto the shared `{CS_N,RAS_N,CAS_N,WE_N}` command bus.

## Interface
- `REF_PERIOD`, default 780: refresh interval in clocks (7.8 µs at 100 MHz).
- `TRP_CLK`, default 2: clocks from PRECHARGE to the first AUTO REFRESH. Minimum 1.
- `TRC_CLK`, default 7: clocks from each AUTO REFRESH to the next command or to done. Minimum 1.
- `Clk` in, 1: system clock. The SDRAM device clock is `~Clk`.
- `Rst_n` in, 1: reset. **One clock; reset is asynchronous and active-low.**
- `Init_done` in, 1: level from `sdram_init`. High means the device is initialised.
- `Aref_en` in, 1: grant from the arbiter. Sampled only in IDLE while `Aref_req` is 1.
- `Aref_req` out, 1: refresh pending.
- `Aref_done` out, 1: one-cycle pulse marking the end of the refresh sequence.
- `Command` out, 4: `{CS_N,RAS_N,CAS_N,WE_N}`.
- `Saddr` out, `` `ASIZE ``: address bus. A10 is 1 during PRECHARGE; all other bits are 0.

## Operation
- Commands used: NOP = 4'b0111, PRECHARGE = 4'b0010, AREF = 4'b0001.
- Refresh timer:
  - Counts 0..`REF_PERIOD`-1 and wraps, only while `Init_done` = 1. It is held at 0 otherwise.
  - On wrap it sets `Aref_req`.
  - It keeps counting during a refresh, so the period is fixed and not stretched by grant latency.
  - A wrap while `Aref_req` is already 1 leaves exactly one request pending. Requests are never queued or counted.
- States: IDLE → PRE → WAIT_RP → AREF1 → WAIT_RC1 → AREF2 → WAIT_RC2 → DONE → IDLE.
  - IDLE → PRE when `Aref_req` = 1 and `Aref_en` = 1.
  - PRE / AREF1 / AREF2 each last 1 cycle.
  - WAIT_RP lasts `TRP_CLK`-1 cycles.
  - WAIT_RC1 and WAIT_RC2 each last `TRC_CLK`-1 cycles.
  - DONE lasts 1 cycle.
- A single delay counter serves all wait states and is cleared on every state entry.
- `Aref_req` clears on the IDLE→PRE transition.
- `Aref_en` behaviour:
  - Ignored outside IDLE, and ignored in IDLE when no request is pending.
  - Holding it high does not chain sequences. A new sequence needs a new timer wrap.
- `Command` is NOP in every state other than PRE, AREF1 and AREF2.
- `Init_done` falling in any state is a synchronous abort:
  - next cycle: state IDLE, `Command` NOP, `Saddr` 0
  - `Aref_req` 0, timer 0
  - no `Aref_done` pulse.

## Timing
- Reset values: `Command` = NOP, `Saddr` = 0, `Aref_req` = 0, `Aref_done` = 0. State is IDLE, timer and delay counter are 0.
- All outputs are registered.
- Grant to first command: if `Aref_en` = 1 is sampled at edge k, PRECHARGE appears at edge k+1 and `Aref_req` falls at edge k+1.
- With PRECHARGE at cycle 0:
  - AREF at cycle `TRP_CLK`
  - AREF at cycle `TRP_CLK`+`TRC_CLK`
  - `Aref_done` = 1 for the single cycle `TRP_CLK`+2·`TRC_CLK`
  - back in IDLE (`Aref_done` = 0) the cycle after.
- First request: `REF_PERIOD` clocks after `Init_done` rises, then every `REF_PERIOD` clocks thereafter.
- Timer wrap and grant in the same cycle: the grant is taken and `Aref_req` is cleared. That wrap is absorbed by the sequence it coincides with.
- Asynchronous `Rst_n` assertion mid-sequence forces reset values immediately, with no clock needed.

## Structure
- Command encodings (NOP, PRECHARGE, AREF) and `` `ASIZE `` live in the shared `params.h`, included by `sdram_init`, `sdram_aref` and the arbiter.
- Natural sub-module `sdram_ref_timer`: the `REF_PERIOD` counter with enable, wrap pulse and sticky request flag.
- The state machine and delay counter stay in `sdram_aref`.

## Test plan
All scenarios use `REF_PERIOD` = 50, `TRP_CLK` = 2, `TRC_CLK` = 7, 100 MHz clock, and `sdram_init` upstream with the `sdr` model on `~Clk`.
1. Reset held, then released:
   - all outputs at reset values while `Init_done` = 0
   - no `Aref_req` for 200 cycles with `Init_done` forced 0.
2. `Init_done` rises, `Aref_en` tied 1:
   - `Aref_req` rises 50 cycles later
   - PRECHARGE with A10 = 1 on the next cycle, then AREF at +2, AREF at +9
   - `Aref_done` pulse at +16
   - the model reports no tRP/tRC violations.
3. `Aref_en` held 0 for 200 cycles: `Aref_req` stays high throughout, and exactly one sequence follows release.
4. `Aref_en` pulses while `Aref_req` = 0, and again mid-sequence: no state change, no extra commands.
5. `Init_done` forced 0 during WAIT_RC1: NOP next cycle, `Aref_req` = 0, no `Aref_done`. After restore, the next request comes 50 cycles later.
6. `Rst_n` asserted during AREF1: `Command` = NOP immediately. After release the FSM is in IDLE and the timer restarts from 0.
